// File: rtl/alu_agent_pkg.sv
// Shared ALU agent types.
// Operation encoding seen by the ALU and its drivers.
package alu_agent_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_type_t;

endpackage

// File: rtl/alu_tracker_pkg.sv
// Request tracker types.
// Default-width request bundle and issue FSM states.
package alu_tracker_pkg;
    import alu_agent_pkg::*;

    localparam int OP_W = $bits(op_type_t);

    typedef struct packed {
        logic [15:0] val1;
        logic [15:0] val2;
        op_type_t    mode;
        logic [31:0] id;
    } alu_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } iss_state_t;

endpackage

// File: rtl/alu_req_tracker_if.sv
// Request, ALU and response bundle of the tracker.
// slave = tracker side, master = source/ALU side.
interface alu_req_tracker_if #(
    parameter int DATA_W  = 16,
    parameter int ID_W    = 32,
    parameter int MAX_OUT = 4
);
    import alu_agent_pkg::*;

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_val1;
    logic [DATA_W-1:0] req_val2;
    op_type_t          req_mode;
    logic [ID_W-1:0]   req_id;

    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    op_type_t          mode;
    logic [ID_W-1:0]   txn_id;
    logic              valid_i;

    logic              valid_o;
    logic [DATA_W-1:0] result;
    logic [ID_W-1:0]   result_id;

    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_val1;
    logic [DATA_W-1:0] rsp_val2;
    op_type_t          rsp_mode;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_timeout;
    logic              err_unexpected;
    logic [CNT_W-1:0]  outstanding;

    modport slave (
        input  req_valid, req_val1, req_val2, req_mode, req_id,
        input  valid_o, result, result_id,
        output req_ready, val1, val2, mode, txn_id, valid_i,
        output rsp_valid, rsp_id, rsp_val1, rsp_val2, rsp_mode,
        output rsp_result, rsp_timeout, err_unexpected, outstanding
    );

    modport master (
        output req_valid, req_val1, req_val2, req_mode, req_id,
        output valid_o, result, result_id,
        input  req_ready, val1, val2, mode, txn_id, valid_i,
        input  rsp_valid, rsp_id, rsp_val1, rsp_val2, rsp_mode,
        input  rsp_result, rsp_timeout, err_unexpected, outstanding
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous FIFO for queued ALU requests.
// Count-based full/empty; DEPTH must be a power of 2.
module alu_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_req_tracker.sv
// Queues tagged ALU requests, issues them one per two cycles and
// tracks outstanding ones until an id-matched result or timeout.
module alu_req_tracker
    import alu_agent_pkg::*;
    import alu_tracker_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ID_W    = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 64
) (
    input logic         clk,
    input logic         rst_n,
    alu_req_tracker_if.slave bus
);
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int SLOT_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int AGE_W  = $clog2(TIMEOUT + 1);
    localparam int FCW    = $clog2(DEPTH + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
    localparam logic [AGE_W-1:0] AGE_EXP = AGE_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        op_type_t          mode;
        logic [ID_W-1:0]   id;
    } ent_t;

    iss_state_t        state;
    logic              run_q;
    logic              valid_q;
    ent_t              drv_q;
    ent_t              push_ent;
    ent_t              head;
    ent_t              issue_ent;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [FCW-1:0]    fcnt;
    logic              issue_ok;

    logic [MAX_OUT-1:0] occ;
    ent_t               slot [MAX_OUT];
    logic [AGE_W-1:0]   age  [MAX_OUT];
    logic [MAX_OUT-1:0] hit;
    logic [MAX_OUT-1:0] expd;
    logic               any_hit;
    logic               any_free;
    logic               ret;
    logic [SLOT_W-1:0]  free_idx;
    logic [SLOT_W-1:0]  hit_idx;
    logic [SLOT_W-1:0]  exp_idx;
    logic [SLOT_W-1:0]  ret_idx;
    logic [CNT_W-1:0]   busy_cnt;

    logic               rsp_valid_q;
    ent_t               rsp_q;
    logic [DATA_W-1:0]  rsp_res_q;
    logic               rsp_to_q;
    logic               err_q;

    assign push_ent = '{val1: bus.req_val1, val2: bus.req_val2,
                        mode: bus.req_mode, id: bus.req_id};
    assign bus.req_ready = run_q && !full;
    assign push      = bus.req_valid && bus.req_ready;
    assign pop       = (state == DRIVE);
    // An empty FIFO forwards the entry being pushed this cycle.
    assign issue_ent = empty ? push_ent : head;
    assign issue_ok  = ((fcnt != '0) || push) && any_free;

    alu_req_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_ent),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fcnt)
    );

    // Slot lookup: lowest free, lowest hit, lowest expired, occupancy.
    always_comb begin
        hit      = '0;
        expd     = '0;
        free_idx = '0;
        hit_idx  = '0;
        exp_idx  = '0;
        busy_cnt = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            hit[i]  = occ[i] && bus.valid_o
                      && (slot[i].id == bus.result_id);
            expd[i] = occ[i] && (age[i] >= AGE_EXP);
            if (!occ[i]) free_idx = SLOT_W'(i);
            if (hit[i])  hit_idx  = SLOT_W'(i);
            if (expd[i]) exp_idx  = SLOT_W'(i);
            busy_cnt = busy_cnt + CNT_W'(occ[i]);
        end
        any_free = ~&occ;
        any_hit  = |hit;
        ret      = any_hit || (|expd);
        ret_idx  = any_hit ? hit_idx : exp_idx;
    end

    // Issue FSM: one-cycle valid_i pulse followed by a mandatory gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
            drv_q   <= '0;
        end else begin
            run_q <= 1'b1;
            unique case (state)
                IDLE, GAP: begin
                    if (issue_ok) begin
                        state   <= DRIVE;
                        valid_q <= 1'b1;
                        drv_q   <= issue_ent;
                    end else begin
                        state   <= IDLE;
                    end
                end
                DRIVE: begin
                    state   <= GAP;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard: aging, allocation on issue, one retirement per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            rsp_res_q   <= '0;
            rsp_to_q    <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) begin
                slot[i] <= '0;
                age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUT; i++) begin
                if (occ[i] && (age[i] != AGE_MAX))
                    age[i] <= age[i] + AGE_W'(1);
            end
            if (ret) occ[ret_idx] <= 1'b0;
            // The issue cycle itself counts as age 0.
            if (pop) begin
                occ[free_idx]  <= 1'b1;
                age[free_idx]  <= AGE_W'(1);
                slot[free_idx] <= drv_q;
            end
            rsp_valid_q <= ret;
            err_q       <= bus.valid_o && !any_hit;
            if (ret) begin
                rsp_q     <= slot[ret_idx];
                rsp_res_q <= any_hit ? bus.result : '0;
                rsp_to_q  <= !any_hit;
            end
        end
    end

    assign bus.valid_i        = valid_q;
    assign bus.val1           = drv_q.val1;
    assign bus.val2           = drv_q.val2;
    assign bus.mode           = drv_q.mode;
    assign bus.txn_id         = drv_q.id;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_id         = rsp_q.id;
    assign bus.rsp_val1       = rsp_q.val1;
    assign bus.rsp_val2       = rsp_q.val2;
    assign bus.rsp_mode       = rsp_q.mode;
    assign bus.rsp_result     = rsp_res_q;
    assign bus.rsp_timeout    = rsp_to_q;
    assign bus.err_unexpected = err_q;
    assign bus.outstanding    = busy_cnt;

endmodule

// File: tb/tb_alu_req_tracker.sv
// Directed bench for alu_req_tracker with a response scoreboard.
// Expected responses carry the cycle they must appear in.
module tb_alu_req_tracker;
    import alu_agent_pkg::*;

    localparam int DATA_W  = 16;
    localparam int ID_W    = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_req_tracker_if #(
        .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(MAX_OUT)
    ) bus ();

    alu_req_tracker #(
        .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH),
        .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] id;
        logic [15:0] v1;
        logic [15:0] v2;
        op_type_t    mode;
        logic [15:0] res;
        logic        to;
        logic [31:0] at;
    } rsp_t;

    rsp_t        sb [$];
    logic [15:0] rv1 [20];
    logic [15:0] rv2 [20];
    op_type_t    rmd [20];
    logic [31:0] rid [20];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int err_at = -1;
    int vi_seen = 0;
    int ta, ti, ia, vi0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t exp_rsp(input int k, input logic [15:0] r,
                                     input logic to, input int at);
        return '{id: rid[k], v1: rv1[k], v2: rv2[k], mode: rmd[k],
                 res: r, to: to, at: at};
    endfunction

    task automatic set_req(input int k, input logic [15:0] a,
                           input logic [15:0] b, input op_type_t m,
                           input logic [31:0] id);
        rv1[k] = a;
        rv2[k] = b;
        rmd[k] = m;
        rid[k] = id;
    endtask

    task automatic tick();
        rsp_t o;
        rsp_t e;
        @(negedge clk);
        cyc++;
        if (bus.valid_i) vi_seen++;
        chk("err_unexpected", 128'(bus.err_unexpected),
            128'(cyc == err_at));
        if (bus.rsp_valid) begin
            o = '{id: bus.rsp_id, v1: bus.rsp_val1, v2: bus.rsp_val2,
                  mode: bus.rsp_mode, res: bus.rsp_result,
                  to: bus.rsp_timeout, at: cyc};
            if (sb.size() == 0) begin
                chk("rsp_stray", 128'(bus.rsp_valid), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("rsp", 128'(o), 128'(e));
            end
        end
    endtask

    task automatic drive_req(input int k);
        chk("req_ready", 128'(bus.req_ready), 128'(1));
        bus.req_valid = 1'b1;
        bus.req_val1  = rv1[k];
        bus.req_val2  = rv2[k];
        bus.req_mode  = rmd[k];
        bus.req_id    = rid[k];
    endtask

    task automatic alu_rsp(input int k, input logic [15:0] r);
        bus.valid_o   = 1'b1;
        bus.result_id = rid[k];
        bus.result    = r;
        sb.push_back(exp_rsp(k, r, 1'b0, cyc + 1));
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_val1  = '0;
        bus.req_val2  = '0;
        bus.req_mode  = ADD;
        bus.req_id    = '0;
        bus.valid_o   = 1'b0;
        bus.result    = '0;
        bus.result_id = '0;

        set_req(0, 16'd3, 16'd4, ADD, 32'd7);
        for (int j = 0; j < 8; j++)
            set_req(1 + j, 16'(j * 3 + 1), 16'(j + 10),
                    op_type_t'(j % 4), 32'(100 + j));
        set_req(9, 16'd5, 16'd6, SUB, 32'd9);
        set_req(10, 16'd1, 16'd2, MUL, 32'd20);
        set_req(11, 16'd8, 16'd9, ADD, 32'd30);
        set_req(12, 16'd10, 16'd11, SUB, 32'd31);
        for (int j = 0; j < 5; j++)
            set_req(13 + j, 16'(j + 50), 16'(j + 60),
                    op_type_t'(j % 4), 32'(40 + j));

        // reset state
        tick();
        tick();
        chk("rst_valid_i", 128'(bus.valid_i), 128'(0));
        chk("rst_ready", 128'(bus.req_ready), 128'(0));
        chk("rst_outst", 128'(bus.outstanding), 128'(0));
        chk("rst_rsp", 128'(bus.rsp_valid), 128'(0));
        chk("rst_txn", 128'(bus.txn_id), 128'(0));
        rst_n = 1'b1;
        tick();
        chk("rel_ready", 128'(bus.req_ready), 128'(1));
        chk("rel_outst", 128'(bus.outstanding), 128'(0));

        // single request, ALU answers 3 cycles after valid_i
        drive_req(0);
        tick();
        bus.req_valid = 1'b0;
        ta = cyc;
        chk("t1_vi", 128'(bus.valid_i), 128'(1));
        chk("t1_val1", 128'(bus.val1), 128'(3));
        chk("t1_val2", 128'(bus.val2), 128'(4));
        chk("t1_mode", 128'(bus.mode), 128'(ADD));
        chk("t1_txn", 128'(bus.txn_id), 128'(7));
        chk("t1_out0", 128'(bus.outstanding), 128'(0));
        tick();
        chk("t1_vi_gap", 128'(bus.valid_i), 128'(0));
        chk("t1_out1", 128'(bus.outstanding), 128'(1));
        while (cyc < ta + 3) tick();
        alu_rsp(0, 16'd7);
        tick();
        bus.valid_o = 1'b0;
        chk("t1_out_end", 128'(bus.outstanding), 128'(0));
        chk("t1_sb", 128'(sb.size()), 128'(0));

        // burst of pushes, slots fill, FIFO fills
        for (int c = 0; c < 12; c++) begin
            if (c < 6) drive_req(1 + c);
            else bus.req_valid = 1'b0;
            tick();
            chk("t2_vi", 128'(bus.valid_i),
                128'(((c % 2) == 0) && (c < 7)));
            if (bus.valid_i)
                chk("t2_txn", 128'(bus.txn_id), 128'(100 + c / 2));
        end
        bus.req_valid = 1'b0;
        chk("t2_out4", 128'(bus.outstanding), 128'(4));
        drive_req(7);
        tick();
        drive_req(8);
        tick();
        bus.req_valid = 1'b0;
        chk("t2_full", 128'(bus.req_ready), 128'(0));
        vi0 = vi_seen;
        tick();
        tick();
        tick();
        chk("t2_stall", 128'(vi_seen), 128'(vi0));
        chk("t2_out_hold", 128'(bus.outstanding), 128'(4));
        alu_rsp(2, 16'h1234);
        tick();
        bus.valid_o = 1'b0;
        chk("t2_out3", 128'(bus.outstanding), 128'(3));
        tick();
        chk("t2_reissue", 128'(bus.valid_i), 128'(1));
        chk("t2_reid", 128'(bus.txn_id), 128'(104));
        tick();
        chk("t2_ready", 128'(bus.req_ready), 128'(1));
        chk("t2_out4b", 128'(bus.outstanding), 128'(4));
        for (int k = 1; k <= 5; k++) begin
            if (k != 2) begin
                alu_rsp(k, 16'(k * 7));
                tick();
                bus.valid_o = 1'b0;
                tick();
            end
        end
        repeat (8) tick();
        for (int k = 6; k <= 8; k++) begin
            alu_rsp(k, 16'(k * 7));
            tick();
            bus.valid_o = 1'b0;
            tick();
        end
        repeat (4) tick();
        chk("t2_drain", 128'(bus.outstanding), 128'(0));
        chk("t2_sb", 128'(sb.size()), 128'(0));

        // timeout of id 9, 64 cycles after its valid_i
        drive_req(9);
        tick();
        bus.req_valid = 1'b0;
        ti = cyc;
        chk("t3_vi", 128'(bus.valid_i), 128'(1));
        chk("t3_txn", 128'(bus.txn_id), 128'(9));
        sb.push_back(exp_rsp(9, 16'd0, 1'b1, ti + TIMEOUT));
        while (cyc < ti + TIMEOUT + 2) begin
            tick();
            if (cyc == ti + TIMEOUT - 1)
                chk("t3_out1", 128'(bus.outstanding), 128'(1));
        end
        chk("t3_out0", 128'(bus.outstanding), 128'(0));
        chk("t3_sb", 128'(sb.size()), 128'(0));

        // unexpected result id
        drive_req(10);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        bus.valid_o   = 1'b1;
        bus.result_id = 32'hDEAD;
        bus.result    = 16'd5;
        err_at = cyc + 1;
        tick();
        bus.valid_o = 1'b0;
        chk("t4_out", 128'(bus.outstanding), 128'(1));
        chk("t4_norsp", 128'(bus.rsp_valid), 128'(0));
        tick();
        alu_rsp(10, 16'd2);
        tick();
        bus.valid_o = 1'b0;
        tick();
        chk("t4_out0", 128'(bus.outstanding), 128'(0));

        // match and expiry in the same cycle
        drive_req(11);
        tick();
        ia = cyc;
        chk("t5_vi", 128'(bus.valid_i), 128'(1));
        drive_req(12);
        tick();
        bus.req_valid = 1'b0;
        while (cyc < ia + TIMEOUT - 1) tick();
        alu_rsp(12, 16'h0BEE);
        sb.push_back(exp_rsp(11, 16'd0, 1'b1, ia + TIMEOUT + 1));
        tick();
        bus.valid_o = 1'b0;
        tick();
        tick();
        chk("t5_sb", 128'(sb.size()), 128'(0));
        chk("t5_out0", 128'(bus.outstanding), 128'(0));

        // reset with 3 outstanding and 2 queued
        for (int c = 0; c < 5; c++) begin
            drive_req(13 + c);
            tick();
        end
        bus.req_valid = 1'b0;
        tick();
        chk("t6_out3", 128'(bus.outstanding), 128'(3));
        rst_n = 1'b0;
        #1;
        chk("t6_vi", 128'(bus.valid_i), 128'(0));
        chk("t6_val1", 128'(bus.val1), 128'(0));
        chk("t6_txn", 128'(bus.txn_id), 128'(0));
        chk("t6_out", 128'(bus.outstanding), 128'(0));
        chk("t6_ready", 128'(bus.req_ready), 128'(0));
        chk("t6_rsp", 128'(bus.rsp_valid), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        vi0 = vi_seen;
        tick();
        chk("t6_ready1", 128'(bus.req_ready), 128'(1));
        chk("t6_out0", 128'(bus.outstanding), 128'(0));
        repeat (80) tick();
        chk("t6_noissue", 128'(vi_seen), 128'(vi0));
        chk("t6_sb", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
